// File: rtl/conv2d_seq_ctrl.sv
// conv2d_seq_ctrl
// Sequencer for the 2D convolution engine. A start fetches the WT_DIM x WT_DIM
// kernel, then the fm_dim x fm_dim feature map, over an in-order read port.
// Each returned word is broadcast to the PE row as a weight or feature-map beat.
// PE results are counted, and a one-cycle done pulse fires once every output
// pixel has been produced.
//
// Handshakes:
//   - Request: a read is accepted on a cycle where req_valid && req_ready.
//     While req_valid is high and req_ready is low, req_valid and req_addr
//     hold steady.
//   - Response: responses cannot be stalled. A resp_valid pulse is consumed
//     only while requests are outstanding (pend != 0).
module conv2d_seq_ctrl #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int WT_DIM  = 3,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] fm_dim,
    input  logic [AWIDTH-1:0] wt_base,
    input  logic [AWIDTH-1:0] fm_base,
    output logic              idle,
    output logic              done,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [AWIDTH-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [DWIDTH-1:0] resp_data,
    output logic [DWIDTH-1:0] fm_dim_o,
    output logic [DWIDTH-1:0] pe_weight_data,
    output logic [DWIDTH-1:0] pe_fm_data,
    output logic              pe_weight_data_valid,
    output logic              pe_fm_data_valid,
    input  logic              pe_res_valid,
    output logic [2:0]        state_dbg
);

    localparam int WT_SIZE = WT_DIM * WT_DIM;
    localparam logic [DWIDTH-1:0] WT_SIZE_D = DWIDTH'(WT_SIZE);
    localparam logic [DWIDTH-1:0] MAX_OUT_D = DWIDTH'(MAX_OUT);
    localparam logic [DWIDTH-1:0] ONE_D     = DWIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WT    = 3'd1,
        S_FM    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;

    // Values latched at start.
    logic [DWIDTH-1:0] fm_dim_r;
    logic [AWIDTH-1:0] wt_base_r;
    logic [AWIDTH-1:0] fm_base_r;
    logic [DWIDTH-1:0] n_total;

    // req_cnt and rsp_cnt are per phase. pend spans phases. out_cnt counts
    // PE results.
    logic [DWIDTH-1:0] req_cnt;
    logic [DWIDTH-1:0] rsp_cnt;
    logic [DWIDTH-1:0] out_cnt;
    logic [DWIDTH-1:0] pend;

    // Single beat register shared by the weight and feature-map buses.
    logic [DWIDTH-1:0] beat_data;
    logic              wt_beat_valid;
    logic              fm_beat_valid;

    logic              in_fetch;
    logic [DWIDTH-1:0] phase_limit;
    logic [AWIDTH-1:0] phase_base;
    logic              req_fire;
    logic              rsp_fire;
    logic [DWIDTH-1:0] n_at_start;

    // Request decode from registered state only.
    // req_valid can drop only after a handshake: a response can only lower
    // pend, and req_cnt advances only on a handshake. A stalled request
    // therefore stays valid, with a steady address.
    always_comb begin
        in_fetch    = (state == S_WT) || (state == S_FM);
        phase_limit = (state == S_FM) ? n_total : WT_SIZE_D;
        phase_base  = (state == S_FM) ? fm_base_r : wt_base_r;
        req_valid   = in_fetch && (req_cnt < phase_limit) && (pend < MAX_OUT_D);
        req_addr    = phase_base + (AWIDTH'(req_cnt) << 2);
        req_fire    = req_valid && req_ready;
        rsp_fire    = resp_valid && (pend != '0) && in_fetch;
        n_at_start  = DWIDTH'(32'(fm_dim[15:0]) * 32'(fm_dim[15:0]));
    end

    assign fm_dim_o             = fm_dim_r;
    assign pe_weight_data       = beat_data;
    assign pe_fm_data           = beat_data;
    assign pe_weight_data_valid = wt_beat_valid;
    assign pe_fm_data_valid     = fm_beat_valid;
    assign state_dbg            = state;

    // Phase sequencing, counters, beat register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idle          <= 1'b1;
            done          <= 1'b0;
            fm_dim_r      <= '0;
            wt_base_r     <= '0;
            fm_base_r     <= '0;
            n_total       <= '0;
            req_cnt       <= '0;
            rsp_cnt       <= '0;
            out_cnt       <= '0;
            pend          <= '0;
            beat_data     <= '0;
            wt_beat_valid <= 1'b0;
            fm_beat_valid <= 1'b0;
        end else begin
            wt_beat_valid <= 1'b0;
            fm_beat_valid <= 1'b0;
            done          <= 1'b0;

            // Each accepted response becomes one beat, tagged by the phase.
            if (rsp_fire) begin
                beat_data     <= resp_data;
                wt_beat_valid <= (state == S_WT);
                fm_beat_valid <= (state == S_FM);
            end

            // A handshake and a response on the same cycle cancel out.
            if (req_fire && !rsp_fire) begin
                pend <= pend + ONE_D;
            end else if (!req_fire && rsp_fire) begin
                pend <= pend - ONE_D;
            end

            if (req_fire) begin
                req_cnt <= req_cnt + ONE_D;
            end
            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + ONE_D;
            end

            // Results only count once the feature map is streaming.
            if (pe_res_valid && ((state == S_FM) || (state == S_DRAIN))) begin
                out_cnt <= out_cnt + ONE_D;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        fm_dim_r  <= fm_dim;
                        wt_base_r <= wt_base;
                        fm_base_r <= fm_base;
                        n_total   <= n_at_start;
                        req_cnt   <= '0;
                        rsp_cnt   <= '0;
                        out_cnt   <= '0;
                        pend      <= '0;
                        idle      <= 1'b0;
                        if (fm_dim == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_WT;
                        end
                    end
                end
                S_WT: begin
                    // Fence: the FM phase opens only after the last weight
                    // response, so the two beat streams never interleave.
                    if (rsp_fire && (rsp_cnt + ONE_D == WT_SIZE_D)) begin
                        state   <= S_FM;
                        req_cnt <= '0;
                        rsp_cnt <= '0;
                    end
                end
                S_FM: begin
                    if (rsp_fire && (rsp_cnt + ONE_D == n_total)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((out_cnt == n_total) ||
                        (pe_res_valid && (out_cnt + ONE_D == n_total))) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/conv2d_seq_ctrl.md
# conv2d_seq_ctrl

Sequencer for the 2D convolution engine. On `start`, it fetches the WT_DIM×WT_DIM kernel and then the fm_dim×fm_dim feature map from memory through a request/response read port. It broadcasts each returned word to the PE row as weight or feature-map beats, counts PE results, and pulses `done` once every output pixel is produced. It sits between the accelerator's CSR/start logic and the conv PE row.

## Interface
- `AWIDTH`, 32, address width (byte addresses)
- `DWIDTH`, 32, data width
- `WT_DIM`, 3, kernel dimension; WT_SIZE = WT_DIM*WT_DIM
- `MAX_OUT`, 4, maximum outstanding read requests (≥1)

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch; sampled only in IDLE
- `fm_dim`  in  DWIDTH  feature-map side; latched at start; legal range 0..65535
- `wt_base`  in  AWIDTH  kernel base byte address, latched at start
- `fm_base`  in  AWIDTH  feature-map base byte address, latched at start
- `idle`  out  1  high only in IDLE
- `done`  out  1  one-cycle completion pulse
- `req_valid`  out  1  read request valid
- `req_ready`  in  1  read request accepted when valid&ready
- `req_addr`  out  AWIDTH  read byte address
- `resp_valid`  in  1  read data valid; responses return in order and cannot be stalled
- `resp_data`  in  DWIDTH  read data
- `fm_dim_o`  out  DWIDTH  latched fm_dim, driven to PEs
- `pe_weight_data`, `pe_fm_data`  out  DWIDTH  registered beat data; both carry the same register
- `pe_weight_data_valid`  out  1  weight beat
- `pe_fm_data_valid`  out  1  feature-map beat
- `pe_res_valid`  in  1  one PE result produced this cycle

## Operation
- States: IDLE → WT → FM → DRAIN → DONE → IDLE.
- **IDLE:**
  - `start`=1 latches fm_dim, wt_base and fm_base, and clears all counters.
  - Next state is WT, or DONE if fm_dim==0.
- **Counters:**
  - `req_cnt` and `rsp_cnt` count within the current phase.
  - `out_cnt` counts results.
  - `pend` = outstanding requests; it spans phases.
- **WT:**
  - `req_valid`=1 while req_cnt<WT_SIZE and pend<MAX_OUT.
  - req_addr = wt_base + 4*req_cnt.
  - Each response produces one weight beat.
  - Move to FM when rsp_cnt reaches WT_SIZE.
  - No FM request is issued until all WT_SIZE weight responses have returned, so weight and FM beats never interleave.
- **FM:**
  - Same rule with limit N = fm_dim*fm_dim; req_addr = fm_base + 4*req_cnt.
  - Each response produces one fm beat.
  - Move to DRAIN when rsp_cnt reaches N.
- **DRAIN:** wait until out_cnt == N, then go to DONE.
- **Result counting:** `pe_res_valid` increments out_cnt in FM and DRAIN. Pulses in IDLE, WT or DONE are ignored.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Arithmetic:**
  - N is computed as a 32-bit product of the 16-bit fm_dim.
  - Addresses wrap modulo 2^AWIDTH.
  - All counters are DWIDTH wide.
- **Error cases:**
  - A `resp_valid` with pend==0 is ignored.
  - A `start` outside IDLE is ignored.
- **Reset:** `rst` at any point forces IDLE, zeroes all counters and clears every valid. Responses still in flight after reset are discarded because pend==0.

## Timing
- Reset values: idle=1, done=0, req_valid=0, req_addr=0, pe_*_valid=0, pe data=0, fm_dim_o=0.
- `start` at cycle T gives req_valid=1 at T+1 with req_addr=wt_base.
- A request handshake at cycle t allows the next request at t+1 (one request per cycle peak).
- A response at cycle R produces pe_*_data and pe_*_valid at R+1 (one register stage).
- pend updates the same cycle as a handshake or response. A simultaneous handshake and response leaves pend unchanged.
- The last weight response at R gives state FM at R+1; the first FM request may assert at R+1.
- The final result at cycle t gives done=1 at t+1 and idle=1 at t+2.
- fm_dim==0: start at T gives done at T+1 and idle at T+2, with no requests.
- req_addr and req_valid hold stable while req_ready=0.

## Test plan
- **Basic run.** fm_dim=2, wt_base=0x100, fm_base=0x200, req_ready=1, responses 2 cycles after accept, pe_res_valid pulsed 4 times.
  - Expect 9 requests 0x100..0x120, then 4 requests 0x200..0x20C.
  - Expect 9 weight beats, then 4 fm beats in order.
  - Expect one done pulse after the 4th result.
- **Backpressure.** req_ready toggled 1/0 and responses delayed 10 cycles.
  - pend never exceeds 4.
  - req_addr is stable while stalled.
  - No beats are lost or duplicated.
- **Phase fence.** 9th weight response delayed 20 cycles.
  - No 0x200 request before that response.
  - First fm beat follows the last weight beat.
- **Zero size.** fm_dim=0.
  - req_valid stays 0.
  - done pulses at T+1; idle at T+2.
- **Reset mid-FM.** rst after 2 fm requests, with 1 response still pending.
  - Next cycle: idle=1, all valids 0.
  - The stale response produces no beat.
  - A new start runs cleanly.
- **Ignored start.** start held high for the whole run.
  - Exactly one run per IDLE entry.
  - Latched fm_dim is unchanged when the input changes mid-run.
